// File: rtl/search_arbiter_if.sv
// search_arbiter_if: requester and search-engine signal bundle for search_arbiter.
// Ports (seen from the arbiter through the master modport):
//   requesters : req_i, req_key_i in; gnt_o, rsp_vd_o, rsp_hit_o, rsp_tab_o, rsp_addr_o, rsp_data_o out
//   engine     : search_o, key_o out; ready_i, busy_i, hit_vd_i, hit_i, hit_tab_i, hit_addr_i, hit_data_i in
//   status     : stray_o, timeout_o out
interface search_arbiter_if #(
    parameter int C_NUM_REQ        = 4,
    parameter int C_NUM_TABLE      = 4,
    parameter int C_RULE_WIDTH     = 24,
    parameter int C_MEM_DATA_WIDTH = 56,
    parameter int C_MEM_ADDR_WIDTH = 8
);
    localparam int DW = C_MEM_DATA_WIDTH - C_RULE_WIDTH;
    logic [C_NUM_REQ-1:0]              req_i;
    logic [C_NUM_REQ*C_RULE_WIDTH-1:0] req_key_i;
    logic [C_NUM_REQ-1:0]              gnt_o;
    logic [C_NUM_REQ-1:0]              rsp_vd_o;
    logic                              rsp_hit_o;
    logic [3:0]                        rsp_tab_o;
    logic [C_MEM_ADDR_WIDTH-1:0]       rsp_addr_o;
    logic [DW-1:0]                     rsp_data_o;
    logic                              search_o;
    logic [C_RULE_WIDTH-1:0]           key_o;
    logic [C_NUM_TABLE-1:0]            ready_i;
    logic [C_NUM_TABLE-1:0]            busy_i;
    logic                              hit_vd_i;
    logic                              hit_i;
    logic [3:0]                        hit_tab_i;
    logic [C_MEM_ADDR_WIDTH-1:0]       hit_addr_i;
    logic [DW-1:0]                     hit_data_i;
    logic                              stray_o;
    logic                              timeout_o;
    modport master (
        input  req_i, req_key_i, ready_i, busy_i, hit_vd_i, hit_i, hit_tab_i, hit_addr_i, hit_data_i,
        output gnt_o, rsp_vd_o, rsp_hit_o, rsp_tab_o, rsp_addr_o, rsp_data_o, search_o, key_o,
               stray_o, timeout_o
    );
    modport slave (
        output req_i, req_key_i, ready_i, busy_i, hit_vd_i, hit_i, hit_tab_i, hit_addr_i, hit_data_i,
        input  gnt_o, rsp_vd_o, rsp_hit_o, rsp_tab_o, rsp_addr_o, rsp_data_o, search_o, key_o,
               stray_o, timeout_o
    );
endinterface

// File: rtl/search_arbiter.sv
// search_arbiter: round-robin sharing of one rule-search engine among C_NUM_REQ requesters.
// Ports: clk_i clock; rstn synchronous active-low reset; io_bus (search_arbiter_if.master)
//   carrying requests/grants/responses, the engine search/result bus and stray/timeout status.
// Optional: define SEARCH_TIMEOUT_EN to abandon a search after C_TIMEOUT WAIT cycles.
module search_arbiter #(
    parameter int C_NUM_REQ        = 4,
    parameter int C_NUM_TABLE      = 4,
    parameter int C_RULE_WIDTH     = 24,
    parameter int C_MEM_DATA_WIDTH = 56,
    parameter int C_MEM_ADDR_WIDTH = 8,
    parameter int C_TIMEOUT        = 64
) (
    input logic               clk_i,
    input logic               rstn,
    search_arbiter_if.master  io_bus
);
    localparam int IW = $clog2(C_NUM_REQ);
    localparam int DW = C_MEM_DATA_WIDTH - C_RULE_WIDTH;
    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;
    state_t                      r_state, w_next;
    logic [IW-1:0]               r_ptr, r_idx, w_win;
    logic [C_RULE_WIDTH-1:0]     r_key;
    logic [C_NUM_REQ-1:0]        r_gnt, r_rsp_vd;
    logic                        r_search, r_rsp_hit, r_stray, r_timeout;
    logic [3:0]                  r_rsp_tab;
    logic [C_MEM_ADDR_WIDTH-1:0] r_rsp_addr;
    logic [DW-1:0]               r_rsp_data;
    logic                        w_arb, w_done, w_to;
    assign w_arb  = (r_state == S_IDLE) && (|io_bus.req_i) && (&io_bus.ready_i) && !(|io_bus.busy_i);
    assign w_done = (r_state == S_WAIT) && io_bus.hit_vd_i;
    // Scan downward so the last match written is the nearest one after the pointer.
    always_comb begin
        w_win = '0;
        for (int k = C_NUM_REQ; k >= 1; k--)
            if (io_bus.req_i[(int'(r_ptr) + k) % C_NUM_REQ]) w_win = IW'((int'(r_ptr) + k) % C_NUM_REQ);
    end
`ifdef SEARCH_TIMEOUT_EN
    localparam int CW = ($clog2(C_TIMEOUT) + 1 > 8) ? $clog2(C_TIMEOUT) + 1 : 8;
    logic [CW-1:0] r_cnt;
    // A hit arriving on the limit cycle takes precedence over the timeout.
    assign w_to = (r_state == S_WAIT) && !io_bus.hit_vd_i && (r_cnt == CW'(C_TIMEOUT - 1));
    always_ff @(posedge clk_i)
        if (!rstn) r_cnt <= '0;
        else       r_cnt <= (r_state == S_WAIT) ? r_cnt + 1'b1 : '0;
`else
    assign w_to = 1'b0;
`endif
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  w_next = w_arb ? S_ISSUE : S_IDLE;
            S_ISSUE: w_next = S_WAIT;
            S_WAIT:  w_next = (w_done || w_to) ? S_IDLE : S_WAIT;
            default: w_next = S_IDLE;
        endcase
    end
    always_ff @(posedge clk_i) begin
        if (!rstn) begin
            r_state    <= S_IDLE;
            r_ptr      <= IW'(C_NUM_REQ - 1);
            r_idx      <= '0;
            r_key      <= '0;
            r_gnt      <= '0;
            r_search   <= 1'b0;
            r_rsp_vd   <= '0;
            r_rsp_hit  <= 1'b0;
            r_rsp_tab  <= '0;
            r_rsp_addr <= '0;
            r_rsp_data <= '0;
            r_stray    <= 1'b0;
            r_timeout  <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_gnt     <= '0;
            r_search  <= 1'b0;
            r_rsp_vd  <= '0;
            r_timeout <= 1'b0;
            // Grant and search strobe are registered at the arbitration edge so they are high during ISSUE.
            if (w_arb) begin
                r_idx    <= w_win;
                r_ptr    <= w_win;
                r_key    <= io_bus.req_key_i[w_win*C_RULE_WIDTH +: C_RULE_WIDTH];
                r_gnt    <= C_NUM_REQ'(1) << w_win;
                r_search <= 1'b1;
            end
            if (w_done) begin
                r_rsp_vd   <= C_NUM_REQ'(1) << r_idx;
                r_rsp_hit  <= io_bus.hit_i;
                r_rsp_tab  <= io_bus.hit_tab_i;
                r_rsp_addr <= io_bus.hit_addr_i;
                r_rsp_data <= io_bus.hit_data_i;
            end
            if (w_to) begin
                r_rsp_vd   <= C_NUM_REQ'(1) << r_idx;
                r_rsp_hit  <= 1'b0;
                r_rsp_tab  <= '0;
                r_rsp_addr <= '0;
                r_rsp_data <= '0;
                r_timeout  <= 1'b1;
            end
            if (io_bus.hit_vd_i && r_state != S_WAIT) r_stray <= 1'b1;
        end
    end
    assign io_bus.gnt_o      = r_gnt;
    assign io_bus.rsp_vd_o   = r_rsp_vd;
    assign io_bus.rsp_hit_o  = r_rsp_hit;
    assign io_bus.rsp_tab_o  = r_rsp_tab;
    assign io_bus.rsp_addr_o = r_rsp_addr;
    assign io_bus.rsp_data_o = r_rsp_data;
    assign io_bus.search_o   = r_search;
    assign io_bus.key_o      = r_key;
    assign io_bus.stray_o    = r_stray;
    assign io_bus.timeout_o  = r_timeout;
endmodule
